// File: rtl/route_sequencer.sv
// route_sequencer: waypoint route controller for the navigation car.
// Walks the route RAM entry by entry. For each entry it turns the car onto the
// entry heading using the compass, then drives forward for the entry distance
// counted in encoder ticks.
//
// Ports:
//   clk_i         system clock
//   rst_i         synchronous active-high reset
//   start_i       one-cycle pulse, begins a route at address 0 (IDLE/ERROR only)
//   abort_i       level, forces motor stop and return to IDLE
//   heading_i     compass heading in degrees 0..359 (>=360 means no sample)
//   enc_tick_i    one-cycle pulse per encoder edge
//   ram_rd_en_o   route RAM read strobe
//   ram_addr_o    route RAM address
//   ram_dout_i    route entry: [92:85] distance, [84] valid, [83:80] heading code
//   motor_o       00 stop, 11 forward, 10 turn right, 01 turn left
//   busy_o        high outside IDLE, DONE and ERROR
//   done_o        one-cycle pulse when the route completes
//   err_o         sticky error flag, cleared by start or reset
//   step_idx_o    index of the entry being executed
module route_sequencer #(
    parameter int unsigned ADDR_W         = 7,
    parameter int unsigned TOL            = 5,
    parameter int unsigned TICKS_PER_UNIT = 16,
    parameter logic [23:0] ALIGN_TIMEOUT  = 24'd10_000_000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [8:0]        heading_i,
    input  logic              enc_tick_i,
    output logic              ram_rd_en_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    input  logic [92:0]       ram_dout_i,
    output logic [1:0]        motor_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] step_idx_o
);

    localparam int unsigned TickW = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
    localparam logic [9:0] TolW   = 10'(TOL);
    localparam logic [9:0] DriftW = 10'(TOL + 5);

    localparam logic [1:0] MotStop  = 2'b00;
    localparam logic [1:0] MotFwd   = 2'b11;
    localparam logic [1:0] MotRight = 2'b10;
    localparam logic [1:0] MotLeft  = 2'b01;

    typedef enum logic [2:0] {
        StIdle, StFetch, StWaitRd, StAlign, StDrive, StNext, StDone, StError
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, step_q, step_d;
    logic [7:0]        dist_q, dist_d, unit_q, unit_d;
    logic [8:0]        target_q, target_d;
    logic [TickW-1:0]  tick_q, tick_d;
    logic [23:0]       tmo_q, tmo_d;
    logic [1:0]        motor_q, motor_d;
    logic              rd_en_q, rd_en_d, busy_q, busy_d, done_q, done_d, err_q, err_d;

    // Route entry fields
    logic [7:0] ent_dist;
    logic       ent_valid;
    logic [3:0] ent_code;
    logic       unused_ram_bits;
    assign ent_dist        = ram_dout_i[92:85];
    assign ent_valid       = ram_dout_i[84];
    assign ent_code        = ram_dout_i[83:80];
    assign unused_ram_bits = ^ram_dout_i[79:0];

    // Heading error: 10-bit intermediates so target+360 cannot overflow
    logic       heading_ok, aligned, drifted, turn_left, start_accept;
    logic [9:0] diff_sum, diff, err_abs;

    always_comb begin
        heading_ok = heading_i < 9'd360;
        diff_sum   = {1'b0, target_q} + 10'd360 - {1'b0, heading_i};
        diff       = (diff_sum >= 10'd360) ? diff_sum - 10'd360 : diff_sum;
        err_abs    = (diff <= 10'd180) ? diff : 10'd360 - diff;
        aligned    = err_abs <= TolW;
        drifted    = err_abs > DriftW;
        turn_left  = diff >= 10'd180;
    end

    assign start_accept = start_i && !abort_i && (state_q == StIdle || state_q == StError);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            step_q   <= '0;
            dist_q   <= '0;
            unit_q   <= '0;
            target_q <= '0;
            tick_q   <= '0;
            tmo_q    <= '0;
            motor_q  <= MotStop;
            rd_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            step_q   <= step_d;
            dist_q   <= dist_d;
            unit_q   <= unit_d;
            target_q <= target_d;
            tick_q   <= tick_d;
            tmo_q    <= tmo_d;
            motor_q  <= motor_d;
            rd_en_q  <= rd_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        step_d   = step_q;
        dist_d   = dist_q;
        unit_d   = unit_q;
        target_d = target_q;
        tick_d   = tick_q;
        // Restarts on every ALIGN entry, including re-entry from DRIVE
        tmo_d    = (state_q == StAlign) ? tmo_q + 24'd1 : '0;

        if (abort_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StError: begin
                    if (start_i) begin
                        addr_d  = '0;
                        step_d  = '0;
                        state_d = StFetch;
                    end
                end
                StFetch: state_d = StWaitRd;
                StWaitRd: begin
                    dist_d   = ent_dist;
                    target_d = {ent_code, 5'b00000} - {3'b000, ent_code, 1'b0};
                    unit_d   = '0;
                    tick_d   = '0;
                    if (!ent_valid) begin
                        state_d = StDone;
                    end else if (ent_code > 4'd11) begin
                        state_d = StError;
                    end else begin
                        state_d = StAlign;
                    end
                end
                StAlign: begin
                    if (tmo_q == ALIGN_TIMEOUT - 24'd1) begin
                        state_d = StError;
                    end else if (heading_ok && aligned) begin
                        state_d = StDrive;
                    end
                end
                StDrive: begin
                    // Transitions need a valid compass sample; ticks are still counted
                    if (heading_ok && unit_q == dist_q) begin
                        state_d = StNext;
                    end else if (heading_ok && drifted) begin
                        state_d = StAlign;
                    end else if (enc_tick_i && unit_q != dist_q) begin
                        if (tick_q == TickW'(TICKS_PER_UNIT - 1)) begin
                            tick_d = '0;
                            unit_d = unit_q + 8'd1;
                        end else begin
                            tick_d = tick_q + 1'b1;
                        end
                    end
                end
                StNext: begin
                    if (addr_q == '1) begin
                        state_d = StDone;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        step_d  = step_q + 1'b1;
                        state_d = StFetch;
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Output logic, registered one cycle after the deciding condition
    always_comb begin
        motor_d = MotStop;
        if (state_d == StDrive && heading_ok) begin
            motor_d = MotFwd;
        end else if (state_d == StAlign && heading_ok && !aligned &&
                     (state_q == StAlign || state_q == StDrive)) begin
            motor_d = turn_left ? MotLeft : MotRight;
        end
        rd_en_d = state_d == StFetch;
        busy_d  = !(state_d == StIdle || state_d == StDone || state_d == StError);
        done_d  = state_d == StDone;
        if (start_accept) begin
            err_d = 1'b0;
        end else if (state_d == StError) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    assign ram_rd_en_o = rd_en_q;
    assign ram_addr_o  = addr_q;
    assign motor_o     = motor_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign step_idx_o  = step_q;

endmodule

// File: tb/tb_route_sequencer.sv
// Bench for route_sequencer: directed routes, a RAM model, and a scoreboard of
// expected output events (motor changes, done pulses, err rising edges).
module tb_route_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, abort, enc_tick;
    logic [8:0]  heading;
    logic        ram_rd_en;
    logic [6:0]  ram_addr;
    logic [92:0] ram_dout;
    logic [1:0]  motor;
    logic        busy, done, err;
    logic [6:0]  step_idx;

    logic [92:0] mem [128];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [1:0] kind;  // 0 motor change, 1 done pulse, 2 err rise
        logic [1:0] val;
    } ev_t;

    ev_t exp_q[$];

    always #5 clk = ~clk;

    route_sequencer #(
        .ADDR_W(7),
        .TOL(5),
        .TICKS_PER_UNIT(16),
        .ALIGN_TIMEOUT(24'd100)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .start_i(start),
        .abort_i(abort),
        .heading_i(heading),
        .enc_tick_i(enc_tick),
        .ram_rd_en_o(ram_rd_en),
        .ram_addr_o(ram_addr),
        .ram_dout_i(ram_dout),
        .motor_o(motor),
        .busy_o(busy),
        .done_o(done),
        .err_o(err),
        .step_idx_o(step_idx)
    );

    // One-cycle read latency route RAM
    always @(posedge clk) begin
        if (ram_rd_en) ram_dout <= mem[ram_addr];
    end

    function automatic logic [92:0] ent(input logic [7:0] d, input logic v, input logic [3:0] c);
        logic [92:0] e;
        e = '0;
        e[92:85] = d;
        e[84] = v;
        e[83:80] = c;
        return e;
    endfunction

    function automatic ev_t ev(input logic [1:0] k, input logic [1:0] v);
        ev_t e;
        e.kind = k;
        e.val = v;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic score(input ev_t got);
        ev_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected event: got kind %0d val %0d, expected none (t=%0t)",
                     got.kind, got.val, $time);
        end else begin
            e = exp_q.pop_front();
            if (e != got) begin
                n_fail++;
                $display("FAIL event order: got kind %0d val %0d, expected kind %0d val %0d (t=%0t)",
                         got.kind, got.val, e.kind, e.val, $time);
            end
        end
    endtask

    // Monitor: samples on the falling edge, scores every observable event
    initial begin
        logic [1:0] prev_motor;
        logic       prev_err;
        prev_motor = 2'b00;
        prev_err = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (motor !== prev_motor) score(ev(2'd0, motor));
                if (done === 1'b1) score(ev(2'd1, 2'd0));
                if (err === 1'b1 && prev_err !== 1'b1) score(ev(2'd2, 2'd0));
            end
            prev_motor = motor;
            prev_err = err;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Start is sampled on the next posedge (cycle N); returns at FETCH (N+1)
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(negedge clk);
            enc_tick = 1'b1;
            @(posedge clk);
            #1;
            enc_tick = 1'b0;
        end
    endtask

    task automatic wait_done(input string name, input int bound);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen = 1'b1;
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at t=%0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit got_err;
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        enc_tick = 1'b0;
        heading = 9'd90;
        for (int i = 0; i < 128; i++) mem[i] = '0;
        cyc(3);
        chk("rst motor", 32'(motor), 32'd0);
        chk("rst rd_en", 32'(ram_rd_en), 32'd0);
        chk("rst addr", 32'(ram_addr), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst err", 32'(err), 32'd0);
        chk("rst step", 32'(step_idx), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc(2);

        // 1: code 3 (90 deg), dist 2, heading 90 -> 32 ticks then done
        mem[0] = ent(8'd2, 1'b1, 4'd3);
        mem[1] = '0;
        exp_q.push_back(ev(2'd0, 2'b11));
        exp_q.push_back(ev(2'd0, 2'b00));
        exp_q.push_back(ev(2'd1, 2'd0));
        pulse_start();
        chk("t1 fetch rd_en", 32'(ram_rd_en), 32'd1);
        chk("t1 fetch addr", 32'(ram_addr), 32'd0);
        chk("t1 busy", 32'(busy), 32'd1);
        cyc(2);
        chk("t1 motor N+3", 32'(motor), 32'd0);
        cyc(1);
        chk("t1 motor N+4", 32'(motor), 32'd3);
        ticks(31);
        chk("t1 motor after 31 ticks", 32'(motor), 32'd3);
        ticks(1);
        chk("t1 motor at 32nd tick", 32'(motor), 32'd3);
        cyc(1);
        chk("t1 motor after 32nd tick", 32'(motor), 32'd0);
        wait_done("t1 done", 20);
        chk("t1 busy at done", 32'(busy), 32'd0);
        chk("t1 step_idx", 32'(step_idx), 32'd1);
        cyc(3);

        // 2: heading 350 vs target 0 -> right; 357 -> drive; 200 vs 30 -> left
        mem[0] = ent(8'd1, 1'b1, 4'd0);
        mem[1] = ent(8'd0, 1'b1, 4'd1);
        mem[2] = '0;
        heading = 9'd350;
        exp_q.push_back(ev(2'd0, 2'b10));
        pulse_start();
        cyc(3);
        chk("t2 motor 350", 32'(motor), 32'd2);
        cyc(3);
        chk("t2 motor 350 held", 32'(motor), 32'd2);
        exp_q.push_back(ev(2'd0, 2'b11));
        exp_q.push_back(ev(2'd0, 2'b00));
        heading = 9'd357;
        cyc(1);
        chk("t2 motor 357", 32'(motor), 32'd3);
        ticks(16);
        cyc(1);
        chk("t2 motor entry0 end", 32'(motor), 32'd0);
        heading = 9'd200;
        exp_q.push_back(ev(2'd0, 2'b01));
        cyc(4);
        chk("t2 motor 200 vs 30", 32'(motor), 32'd1);
        chk("t2 step_idx", 32'(step_idx), 32'd1);
        exp_q.push_back(ev(2'd0, 2'b11));
        exp_q.push_back(ev(2'd0, 2'b00));
        exp_q.push_back(ev(2'd1, 2'd0));
        heading = 9'd30;
        wait_done("t2 done", 20);
        cyc(3);

        // 3: code 12 -> error; later start clears err and refetches address 0
        mem[0] = ent(8'd1, 1'b1, 4'd12);
        exp_q.push_back(ev(2'd2, 2'd0));
        pulse_start();
        got_err = 1'b0;
        for (int i = 0; i < 10 && !got_err; i++) begin
            cyc(1);
            if (err === 1'b1) got_err = 1'b1;
        end
        chk("t3 err set", 32'(got_err), 32'd1);
        chk("t3 motor", 32'(motor), 32'd0);
        chk("t3 busy", 32'(busy), 32'd0);
        cyc(3);
        chk("t3 err sticky", 32'(err), 32'd1);
        mem[0] = '0;
        exp_q.push_back(ev(2'd1, 2'd0));
        pulse_start();
        chk("t3 err cleared", 32'(err), 32'd0);
        chk("t3 refetch rd_en", 32'(ram_rd_en), 32'd1);
        chk("t3 refetch addr", 32'(ram_addr), 32'd0);
        wait_done("t3 done", 10);
        cyc(3);

        // 4: drift 15 deg after 1 of 2 units -> realign, then 16 more ticks
        mem[0] = ent(8'd2, 1'b1, 4'd3);
        mem[1] = '0;
        heading = 9'd90;
        exp_q.push_back(ev(2'd0, 2'b11));
        pulse_start();
        cyc(3);
        chk("t4 motor drive", 32'(motor), 32'd3);
        ticks(16);
        pulse_start();
        chk("t4 start while busy rd_en", 32'(ram_rd_en), 32'd0);
        chk("t4 start while busy motor", 32'(motor), 32'd3);
        exp_q.push_back(ev(2'd0, 2'b01));
        exp_q.push_back(ev(2'd0, 2'b11));
        exp_q.push_back(ev(2'd0, 2'b00));
        exp_q.push_back(ev(2'd1, 2'd0));
        heading = 9'd105;
        cyc(1);
        chk("t4 realign motor", 32'(motor), 32'd1);
        cyc(3);
        chk("t4 realign held", 32'(motor), 32'd1);
        heading = 9'd90;
        cyc(1);
        chk("t4 drive resumed", 32'(motor), 32'd3);
        ticks(15);
        chk("t4 after 15 ticks", 32'(motor), 32'd3);
        ticks(1);
        cyc(1);
        chk("t4 after 16 ticks", 32'(motor), 32'd0);
        wait_done("t4 done", 20);
        cyc(3);

        // 5: stuck misaligned -> error 100 cycles after ALIGN entry
        mem[0] = ent(8'd1, 1'b1, 4'd3);
        heading = 9'd0;
        exp_q.push_back(ev(2'd0, 2'b10));
        exp_q.push_back(ev(2'd0, 2'b00));
        exp_q.push_back(ev(2'd0, 2'b10));
        exp_q.push_back(ev(2'd0, 2'b00));
        exp_q.push_back(ev(2'd2, 2'd0));
        pulse_start();               // FETCH; ALIGN entered after the third posedge
        cyc(3);
        chk("t5 turn right", 32'(motor), 32'd2);
        cyc(7);
        heading = 9'd400;
        cyc(1);
        chk("t5 invalid heading motor", 32'(motor), 32'd0);
        heading = 9'd0;
        cyc(1);
        chk("t5 valid again motor", 32'(motor), 32'd2);
        cyc(89);
        chk("t5 err before timeout", 32'(err), 32'd0);
        chk("t5 motor before timeout", 32'(motor), 32'd2);
        cyc(1);
        chk("t5 err at timeout", 32'(err), 32'd1);
        chk("t5 motor at timeout", 32'(motor), 32'd0);
        cyc(3);

        // 6: abort together with start mid-DRIVE
        mem[0] = ent(8'd2, 1'b1, 4'd3);
        heading = 9'd90;
        exp_q.push_back(ev(2'd0, 2'b11));
        exp_q.push_back(ev(2'd0, 2'b00));
        pulse_start();
        chk("t6 err cleared", 32'(err), 32'd0);
        cyc(3);
        chk("t6 drive", 32'(motor), 32'd3);
        ticks(5);
        @(negedge clk);
        abort = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        start = 1'b0;
        chk("t6 abort motor", 32'(motor), 32'd0);
        chk("t6 abort busy", 32'(busy), 32'd0);
        chk("t6 abort rd_en", 32'(ram_rd_en), 32'd0);
        chk("t6 abort step", 32'(step_idx), 32'd0);
        cyc(10);
        chk("t6 stays idle", 32'(busy), 32'd0);

        // 7: all 128 entries valid with distance 0 -> done after last, no wrap
        for (int i = 0; i < 128; i++) begin
            mem[i] = ent(8'd0, 1'b1, 4'd3);
            exp_q.push_back(ev(2'd0, 2'b11));
            exp_q.push_back(ev(2'd0, 2'b00));
        end
        exp_q.push_back(ev(2'd1, 2'd0));
        pulse_start();
        wait_done("t7 done", 2000);
        chk("t7 step_idx", 32'(step_idx), 32'd127);
        chk("t7 addr", 32'(ram_addr), 32'd127);
        cyc(5);
        chk("t7 no wrap busy", 32'(busy), 32'd0);
        chk("t7 no wrap rd_en", 32'(ram_rd_en), 32'd0);

        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
